alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer has an operation on ALUControl/SrcA/SrcB.
REQ-005 in_ready  output  1  block can accept an operation this cycle; driven from a register.
REQ-006 ALUControl  input  3  operation code from the ALU decoder.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B.
REQ-009 out_valid  output  1  ALUResult and flags hold a completed operation.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 ALUResult  output  WIDTH  result of the head operation.
REQ-012 Zero, Negative, Carry, Overflow  output  1 each  flags of the head operation.
REQ-013 illegal_op  output  1  head operation carried an undefined ALUControl code.

Function
REQ-014 Accept occurs when in_valid && in_ready are both 1 at a rising edge; transfer occurs when out_valid && out_ready are both 1.
REQ-015 Codes: 000 add; 001 sub; 010 and; 011 or; 101 slt (signed); 100, 110 and 111 are illegal.
REQ-016 add: ALUResult = SrcA+SrcB mod 2^WIDTH; Carry = carry-out; Overflow = signed overflow.
REQ-017 sub: computed as SrcA + ~SrcB + 1; Carry = carry-out (1 when SrcA >= SrcB unsigned); Overflow = signed overflow.
REQ-018 slt: ALUResult = 1 when SrcA < SrcB signed (Negative XOR Overflow of the subtraction), else 0; Carry = Overflow = 0.
REQ-019 and/or: bitwise result; Carry = Overflow = 0.
REQ-020 Zero = (ALUResult == 0); Negative = ALUResult[WIDTH-1], for every legal code.
REQ-021 Illegal code: ALUResult = 0, Zero = 1, Negative = Carry = Overflow = 0, illegal_op = 1; legal codes give illegal_op = 0.
REQ-022 Result computed combinationally at accept and stored in a 2-entry in-order result buffer; latency accept -> out_valid = 1 cycle.
REQ-023 Buffer occupancy states EMPTY(0), ONE(1), FULL(2); in_ready = 1 in EMPTY and ONE, 0 in FULL.
REQ-024 Transitions: EMPTY+accept -> ONE; ONE+accept-only -> FULL; ONE+transfer-only -> EMPTY; ONE+accept+transfer -> ONE; FULL+transfer -> ONE; no event -> hold.
REQ-025 No same-cycle bypass: an operation accepted in cycle N is never presented before cycle N+1.
REQ-026 While out_valid=1 and out_ready=0, ALUResult, flags and illegal_op hold stable.
REQ-027 out_valid = 1 whenever occupancy is non-zero; outputs show the oldest entry.
REQ-028 in_valid while in_ready=0 is ignored; inputs are not sampled.
REQ-029 Sustained throughput is one operation per cycle when out_ready is held 1.

Reset
REQ-030 reset=1 at a rising edge empties the buffer, discarding any held results.
REQ-031 During and after reset: out_valid=0, in_ready=1, ALUResult=0, all flags and illegal_op=0.
REQ-032 An accept or transfer coinciding with reset is discarded; reset has priority.
REQ-033 Buffer data registers are also cleared on reset.

Structure
REQ-034 ALUControl code constants (ADD, SUB, AND, OR, SLT) belong in the shared core package used by the ALU decoder.
REQ-035 The flag/result entry record (result + 5 flag bits) is defined in that package.
REQ-036 Pure combinational sub-module alu_core (ALUControl, SrcA, SrcB -> result, flags, illegal_op); alu_exec adds buffering and handshake.

Verification
REQ-037 add 0x7FFFFFFF + 0x00000001 -> ALUResult 0x80000000, N=1, V=1, C=0, Z=0, one cycle after accept.
REQ-038 sub 0x00000005 - 0x00000005 -> ALUResult 0, Z=1, C=1, V=0; slt 0xFFFFFFFF vs 0x00000001 -> ALUResult 1.
REQ-039 Code 110, SrcA=3, SrcB=4 -> ALUResult 0, Z=1, illegal_op=1.
REQ-040 out_ready=0, three back-to-back in_valid ops -> first two accepted, in_ready=0 from cycle after second accept; raise out_ready -> results delivered in order, outputs stable while stalled.
REQ-041 out_ready=1, 10 ops back-to-back -> 10 results on consecutive cycles, in_ready stays 1.
REQ-042 reset asserted with FULL buffer and in_valid=1 -> next cycle out_valid=0, in_ready=1, all outputs 0, no stale result delivered afterwards.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared core package: ALUControl codes, buffered result record, occupancy states.
package alu_exec_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned MAX_WIDTH = 64;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [OP_W-1:0] ALU_SLT = 3'b101;

    // Result plus five flag bits; result is sized for the widest legal datapath.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] result;
        logic                 zero;
        logic                 negative;
        logic                 carry;
        logic                 overflow;
        logic                 illegal;
    } alu_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] code);
        return (code == ALU_ADD) || (code == ALU_SUB) || (code == ALU_AND) ||
               (code == ALU_OR)  || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Purely combinational ALU: result and flags for one operation.
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] add_full;
    logic [WIDTH:0] sub_full;
    logic           add_ovf;
    logic           sub_ovf;

    // Shared adder paths; subtraction is A + ~B + 1 so carry-out means A >= B unsigned.
    always_comb begin
        add_full = {1'b0, src_a} + {1'b0, src_b};
        sub_full = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
        add_ovf  = (src_a[MSB] == src_b[MSB]) && (add_full[MSB] != src_a[MSB]);
        sub_ovf  = (src_a[MSB] != src_b[MSB]) && (sub_full[MSB] != src_a[MSB]);
    end

    // Operation select; illegal codes fall through to an all-zero result.
    always_comb begin
        result     = '0;
        carry      = 1'b0;
        overflow   = 1'b0;
        illegal_op = !is_legal_op(alu_control);
        case (alu_control)
            ALU_ADD: begin
                result   = add_full[MSB:0];
                carry    = add_full[WIDTH];
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = sub_full[MSB:0];
                carry    = sub_full[WIDTH];
                overflow = sub_ovf;
            end
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_SLT: result = WIDTH'(sub_full[MSB] ^ sub_ovf);
            default: result = '0;
        endcase
        zero     = (result == '0);
        negative = result[MSB];
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: combinational ALU feeding a 2-entry in-order result buffer.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             illegal_op
);

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_negative;
    logic             core_carry;
    logic             core_overflow;
    logic             core_illegal;

    alu_entry_t new_entry;
    alu_entry_t head_q;
    alu_entry_t tail_q;
    alu_entry_t head_nxt;
    alu_entry_t tail_nxt;
    occ_state_t state_q;
    occ_state_t state_nxt;
    logic       accept;
    logic       transfer;
    logic       unused_head_hi;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .alu_control (ALUControl),
        .src_a       (SrcA),
        .src_b       (SrcB),
        .result      (core_result),
        .zero        (core_zero),
        .negative    (core_negative),
        .carry       (core_carry),
        .overflow    (core_overflow),
        .illegal_op  (core_illegal)
    );

    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Pack the freshly computed operation into a buffer record.
    always_comb begin
        new_entry          = '0;
        new_entry.result   = MAX_WIDTH'(core_result);
        new_entry.zero     = core_zero;
        new_entry.negative = core_negative;
        new_entry.carry    = core_carry;
        new_entry.overflow = core_overflow;
        new_entry.illegal  = core_illegal;
    end

    // Occupancy next-state and buffer steering; head is always the oldest entry.
    always_comb begin
        state_nxt = state_q;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    head_nxt  = new_entry;
                    state_nxt = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && transfer) begin
                    head_nxt = new_entry;
                end else if (accept) begin
                    tail_nxt  = new_entry;
                    state_nxt = OCC_FULL;
                end else if (transfer) begin
                    head_nxt  = '0;
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (transfer) begin
                    head_nxt  = tail_q;
                    tail_nxt  = '0;
                    state_nxt = OCC_ONE;
                end
            end
            default: begin
                head_nxt  = '0;
                tail_nxt  = '0;
                state_nxt = OCC_EMPTY;
            end
        endcase
    end

    // State, buffer and handshake registers; reset wins over any same-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OCC_EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            head_q    <= head_nxt;
            tail_q    <= tail_nxt;
            out_valid <= (state_nxt != OCC_EMPTY);
            in_ready  <= (state_nxt != OCC_FULL);
        end
    end

    assign ALUResult  = head_q.result[WIDTH-1:0];
    assign Zero       = head_q.zero;
    assign Negative   = head_q.negative;
    assign Carry      = head_q.carry;
    assign Overflow   = head_q.overflow;
    assign illegal_op = head_q.illegal;

    // Upper result bits beyond WIDTH are always zero and intentionally unread.
    assign unused_head_hi = ^head_q.result;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases plus randomized traffic
// checked against a queue-based reference of the 2-deep result buffer.
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         ill;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         Negative;
    logic         Carry;
    logic         Overflow;
    logic         illegal_op;

    int   checks;
    int   errors;
    int   xfer_count;
    exp_t q[$];

    alu_exec #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from arithmetic definitions (wide signed/unsigned math).
    function automatic exp_t ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        sr = 0;
        case (op)
            3'b000: begin
                e.r = a + b;
                e.c = (ua + ub) >= 64'h1_0000_0000;
                sr  = sa + sb;
                e.v = (sr != longint'($signed(e.r)));
            end
            3'b001: begin
                e.r = a - b;
                e.c = (ua >= ub);
                sr  = sa - sb;
                e.v = (sr != longint'($signed(e.r)));
            end
            3'b010: e.r = a & b;
            3'b011: e.r = a | b;
            3'b101: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[W-1];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check current outputs against the model, apply inputs for one edge, update the model.
    task automatic step(input logic rst, input logic iv, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
        logic acc;
        logic xfer;
        reset      = rst;
        in_valid   = iv;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        out_ready  = ordy;
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("result", 64'(ALUResult), 64'(q[0].r));
            chk("flags_zncv", 64'({Zero, Negative, Carry, Overflow}),
                64'({q[0].z, q[0].n, q[0].c, q[0].v}));
            chk("illegal_op", 64'(illegal_op), 64'(q[0].ill));
        end
        acc  = iv && (q.size() < 2);
        xfer = ordy && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (xfer) begin
                void'(q.pop_front());
                xfer_count++;
            end
            if (acc) q.push_back(ref_op(op, a, b));
        end
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_result"}, 64'(ALUResult), 64'(0));
        chk({tag, "_flags"}, 64'({Zero, Negative, Carry, Overflow, illegal_op}), 64'(0));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners[6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        corners[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return W'($urandom);
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        xfer_count = 0;
        reset      = 1'b1;
        in_valid   = 1'b1;
        ALUControl = ALU_ADD;
        SrcA       = 32'd1;
        SrcB       = 32'd2;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");

        // Signed overflow on add, visible one cycle after accept.
        step(1'b0, 1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        chk("add_ovf_valid", 64'(out_valid), 64'(1));
        chk("add_ovf_result", 64'(ALUResult), 64'(32'h8000_0000));
        chk("add_ovf_zncv", 64'({Zero, Negative, Carry, Overflow}), 64'(4'b0101));

        step(1'b0, 1'b1, ALU_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1);
        chk("sub_eq_result", 64'(ALUResult), 64'(0));
        chk("sub_eq_zcv", 64'({Zero, Carry, Overflow}), 64'(3'b110));

        step(1'b0, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        chk("slt_neg_result", 64'(ALUResult), 64'(1));

        step(1'b0, 1'b1, 3'b110, 32'd3, 32'd4, 1'b1);
        chk("illegal_result", 64'(ALUResult), 64'(0));
        chk("illegal_zero_ill", 64'({Zero, illegal_op}), 64'(2'b11));

        step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        chk("drain_empty", 64'(out_valid), 64'(0));

        // Stalled consumer: two accepted, third ignored, then in-order delivery.
        step(1'b0, 1'b1, ALU_OR,  32'h0F0F_0000, 32'h0000_00F0, 1'b0);
        step(1'b0, 1'b1, ALU_AND, 32'hFFFF_00FF, 32'h1234_5678, 1'b0);
        chk("stall_full_in_ready", 64'(in_ready), 64'(0));
        step(1'b0, 1'b1, ALU_SUB, 32'd1, 32'd2, 1'b0);
        step(1'b0, 1'b1, ALU_ADD, 32'd9, 32'd9, 1'b0);
        chk("stall_head_stable", 64'(ALUResult), 64'(32'h0F0F_00F0));
        step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        chk("stall_second", 64'(ALUResult), 64'(32'h1234_0078));
        step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        chk("stall_third_dropped", 64'(out_valid), 64'(0));

        // Back-to-back ops with a ready consumer: one result per cycle.
        xfer_count = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
            chk("b2b_in_ready", 64'(in_ready), 64'(1));
            chk("b2b_out_valid", 64'(out_valid), 64'(1));
        end
        step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        chk("b2b_delivered", 64'(xfer_count), 64'(10));

        // Reset with a full buffer and a pending producer.
        step(1'b0, 1'b1, ALU_ADD, 32'd7, 32'd8, 1'b0);
        step(1'b0, 1'b1, ALU_SUB, 32'd1, 32'd8, 1'b0);
        step(1'b1, 1'b1, ALU_OR, 32'hFF, 32'h1, 1'b1);
        chk_idle("reset_full");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step(1'b0 || ($urandom_range(0, 63) == 0),
                 $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)),
                 pick_operand(), pick_operand(),
                 $urandom_range(0, 2) != 0);
        end
        step(1'b0, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
